// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transceiver: parity encodings,
// FSM state types and the bit-period helper.
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy output.
// Writes while full and reads while empty are ignored.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    // Head reads as zero when empty so stale entries never leak out after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: rtl/uart_fifo_transceiver.sv
// Buffered UART endpoint: TX/RX FIFOs, configurable parity and stop bits,
// per-word error tags and sticky overrun. Optional UART_FIFO_LOOPBACK_EN adds IN_LOOPBACK.
module uart_fifo_transceiver
    import uart_pkg::*;
#(
    parameter int UART_BAUD_RATE           = 9600,
    parameter int CLOCK_FREQUENCY          = 38400,
    parameter int PARITY                   = 2,
    parameter int NUM_OF_DATA_BITS_IN_PACK = 8,
    parameter int NUMBER_STOP_BITS         = 1,
    parameter int FIFO_DEPTH               = 16
) (
    input  logic                                IN_CLOCK,
    input  logic                                IN_RESET_N,
    input  logic [NUM_OF_DATA_BITS_IN_PACK-1:0] IN_TX_DATA,
    input  logic                                IN_TX_VALID,
    output logic                                OUT_TX_READY,
    output logic [NUM_OF_DATA_BITS_IN_PACK-1:0] OUT_RX_DATA,
    output logic                                OUT_RX_PARITY_ERR,
    output logic                                OUT_RX_FRAME_ERR,
    output logic                                OUT_RX_VALID,
    input  logic                                IN_RX_READY,
    output logic                                OUT_RX_OVERRUN,
    input  logic                                IN_OVERRUN_CLEAR,
    output logic                                OUT_TX_BUSY,
    output logic [$clog2(FIFO_DEPTH):0]         OUT_TX_LEVEL,
    output logic [$clog2(FIFO_DEPTH):0]         OUT_RX_LEVEL,
`ifdef UART_FIFO_LOOPBACK_EN
    input  logic                                IN_LOOPBACK,
`endif
    input  logic                                IN_RX_SERIAL,
    output logic                                OUT_TX_SERIAL
);
    localparam int             CPB       = clks_per_bit(CLOCK_FREQUENCY, UART_BAUD_RATE);
    localparam int             DW        = NUM_OF_DATA_BITS_IN_PACK;
    localparam int             CW        = $clog2(CPB) + 1;
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0]  BIT_MID   = CW'(CPB / 2);
    localparam logic [3:0]     DATA_LAST = 4'(DW - 1);
    localparam logic [3:0]     STOP_LAST = 4'(NUMBER_STOP_BITS - 1);
    localparam logic           PAR_ODD   = (PARITY == PARITY_ODD);
    localparam logic           PAR_EN    = (PARITY != PARITY_NONE);

    // ---------------- TX path ----------------
    logic          tx_pop, tx_empty, tx_full;
    logic [DW-1:0] tx_head;
    tx_state_t     tx_state;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_idx;
    logic [DW-1:0] tx_shift;
    logic          tx_par, tx_line, tx_bit_end;

    uart_sync_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(IN_CLOCK), .rst_n(IN_RESET_N),
        .wr_en(IN_TX_VALID), .wr_data(IN_TX_DATA),
        .rd_en(tx_pop), .rd_data(tx_head),
        .level(OUT_TX_LEVEL), .full(tx_full), .empty(tx_empty)
    );
    assign OUT_TX_READY = !tx_full;

    assign tx_bit_end = (tx_cnt == BIT_LAST);
    // Popping on the last stop cycle chains frames with no idle gap.
    assign tx_pop = !tx_empty && ((tx_state == TX_IDLE) ||
                    (tx_state == TX_STOP && tx_bit_end && tx_idx == STOP_LAST));

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            tx_state    <= TX_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_line     <= 1'b1;
            OUT_TX_BUSY <= 1'b0;
        end else begin
            // Line and busy follow the state one cycle later, keeping each bit CPB cycles wide.
            OUT_TX_BUSY <= (tx_state != TX_IDLE);
            case (tx_state)
                TX_START:  tx_line <= 1'b0;
                TX_DATA:   tx_line <= tx_shift[0];
                TX_PARITY: tx_line <= tx_par;
                default:   tx_line <= 1'b1;
            endcase
            if (tx_pop) begin
                tx_shift <= tx_head;
                tx_par   <= ^tx_head ^ PAR_ODD;
                tx_state <= TX_START;
                tx_cnt   <= '0;
                tx_idx   <= '0;
            end else if (tx_state == TX_IDLE) begin
                tx_cnt <= '0;
            end else if (!tx_bit_end) begin
                tx_cnt <= tx_cnt + 1'b1;
            end else begin
                tx_cnt <= '0;
                case (tx_state)
                    TX_START: tx_state <= TX_DATA;
                    TX_DATA: begin
                        tx_shift <= tx_shift >> 1;
                        if (tx_idx == DATA_LAST) begin
                            tx_idx   <= '0;
                            tx_state <= PAR_EN ? TX_PARITY : TX_STOP;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end
                    TX_PARITY: tx_state <= TX_STOP;
                    TX_STOP: begin
                        if (tx_idx == STOP_LAST) tx_state <= TX_IDLE;
                        else                     tx_idx   <= tx_idx + 1'b1;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    // ---------------- line routing ----------------
    logic rx_line;
`ifdef UART_FIFO_LOOPBACK_EN
    assign rx_line       = IN_LOOPBACK ? tx_line : IN_RX_SERIAL;
    assign OUT_TX_SERIAL = tx_line | IN_LOOPBACK;
`else
    assign rx_line       = IN_RX_SERIAL;
    assign OUT_TX_SERIAL = tx_line;
`endif

    // ---------------- RX path ----------------
    logic            rx_meta, rx_sync, rx_prev;
    rx_state_t       rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [3:0]      rx_idx;
    logic [DW-1:0]   rx_shift;
    logic            rx_perr, rx_ferr;
    logic            rx_sample, rx_push, rx_full, rx_empty;
    logic [DW+1:0]   rx_word, rx_head;

    assign rx_sample = (rx_cnt == BIT_LAST);
    assign rx_push   = (rx_state == RX_STOP) && rx_sample && (rx_idx == STOP_LAST);
    assign rx_word   = {rx_ferr | !rx_sync, rx_perr, rx_shift};

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta <= rx_line;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_state <= RX_START;
                        rx_cnt   <= CW'(1);
                        rx_idx   <= '0;
                        rx_perr  <= 1'b0;
                        rx_ferr  <= 1'b0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == BIT_MID) begin
                        rx_cnt   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (!rx_sample) begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end else begin
                        rx_cnt <= '0;
                        case (rx_state)
                            RX_DATA: begin
                                rx_shift <= {rx_sync, rx_shift[DW-1:1]};
                                if (rx_idx == DATA_LAST) begin
                                    rx_idx   <= '0;
                                    rx_state <= PAR_EN ? RX_PARITY : RX_STOP;
                                end else begin
                                    rx_idx <= rx_idx + 1'b1;
                                end
                            end
                            RX_PARITY: begin
                                rx_perr  <= rx_sync ^ (^rx_shift) ^ PAR_ODD;
                                rx_state <= RX_STOP;
                            end
                            RX_STOP: begin
                                rx_ferr <= rx_ferr | !rx_sync;
                                if (rx_idx == STOP_LAST) rx_state <= RX_IDLE;
                                else                     rx_idx   <= rx_idx + 1'b1;
                            end
                            default: rx_state <= RX_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    uart_sync_fifo #(.WIDTH(DW + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(IN_CLOCK), .rst_n(IN_RESET_N),
        .wr_en(rx_push), .wr_data(rx_word),
        .rd_en(IN_RX_READY), .rd_data(rx_head),
        .level(OUT_RX_LEVEL), .full(rx_full), .empty(rx_empty)
    );
    assign OUT_RX_VALID      = !rx_empty;
    assign OUT_RX_DATA       = rx_head[DW-1:0];
    assign OUT_RX_PARITY_ERR = rx_head[DW];
    assign OUT_RX_FRAME_ERR  = rx_head[DW+1];

    always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
        if (!IN_RESET_N)                OUT_RX_OVERRUN <= 1'b0;
        else if (rx_push && rx_full)    OUT_RX_OVERRUN <= 1'b1;
        else if (IN_OVERRUN_CLEAR)      OUT_RX_OVERRUN <= 1'b0;
    end
endmodule

// File: doc/uart_fifo_transceiver.md
# uart_fifo_transceiver

Buffered, parametrised successor to the single-frame UART transceiver. It adds TX and RX FIFOs with valid/ready handshakes, three parity modes, 1 or 2 stop bits, and per-word error tagging (parity, framing) plus a sticky overrun flag. It sits between a host-side streaming interface and the two UART pins of one link endpoint; two instances cross-connected form the standard link bench.

## Interface
- UART_BAUD_RATE, 9600: line bit rate.
- CLOCK_FREQUENCY, 38400: IN_CLOCK frequency in Hz; CLKS_PER_BIT = CLOCK_FREQUENCY/UART_BAUD_RATE (integer division), must be ≥ 4.
- PARITY, 2: 0 none, 1 odd, 2 even.
- NUM_OF_DATA_BITS_IN_PACK, 8: data bits per frame, 5..9, LSB first.
- NUMBER_STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: entries per FIFO, power of two, ≥ 2.

Ports:
- IN_CLOCK  in  1  single system clock.
- IN_RESET_N  in  1  asynchronous, active-low reset.
- IN_TX_DATA  in  NUM_OF_DATA_BITS_IN_PACK  word to send.
- IN_TX_VALID  in  1  push request.
- OUT_TX_READY  out  1  TX FIFO not full.
- OUT_RX_DATA  out  NUM_OF_DATA_BITS_IN_PACK  head of RX FIFO (first-word fall-through).
- OUT_RX_PARITY_ERR  out  1  head word had a parity error.
- OUT_RX_FRAME_ERR  out  1  head word had a low stop bit.
- OUT_RX_VALID  out  1  RX FIFO not empty.
- IN_RX_READY  in  1  pop request.
- OUT_RX_OVERRUN  out  1  sticky: frame dropped because RX FIFO was full.
- IN_OVERRUN_CLEAR  in  1  clears OUT_RX_OVERRUN.
- OUT_TX_BUSY  out  1  TX FSM not IDLE.
- OUT_TX_LEVEL, OUT_RX_LEVEL  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- IN_RX_SERIAL  in  1  line input, asynchronous.
- OUT_TX_SERIAL  out  1  line output, registered.

## Operation
- Reset values: OUT_TX_SERIAL 1, OUT_TX_READY 1, OUT_RX_VALID 0, OUT_RX_DATA 0, both error tags 0, OUT_RX_OVERRUN 0, OUT_TX_BUSY 0, levels 0. Reset mid-frame aborts both FSMs, empties both FIFOs, and drives the line high immediately.
- Push occurs when IN_TX_VALID && OUT_TX_READY. Pop occurs when OUT_RX_VALID && IN_RX_READY. Requests while not ready or not valid are ignored.
- TX FSM: IDLE→START→DATA→(PARITY if PARITY≠0)→STOP→IDLE. Each bit lasts CLKS_PER_BIT cycles. STOP lasts NUMBER_STOP_BITS bits. In IDLE with the FIFO non-empty, the FSM pops and enters START; back-to-back frames have no idle gap.
- Parity bit: even gives XOR of the data bits; odd gives its inverse.
- RX path: 2-FF synchronizer on IN_RX_SERIAL. RX FSM: IDLE→START→DATA→(PARITY)→STOP→IDLE.
  - A falling edge in IDLE starts a count. At CLKS_PER_BIT/2 the line is sampled. If it is high, this is a false start and the FSM returns to IDLE.
  - Every later bit is sampled at mid-bit.
  - Every stop bit is sampled; any low sample sets the frame error tag.
  - At the mid-sample of the last stop bit, the word plus its two tags is pushed and the FSM returns to IDLE, so it can resync on the next edge.
- RX FIFO full at push time: the frame is discarded, FIFO contents are unchanged, and OUT_RX_OVERRUN is set. IN_OVERRUN_CLEAR clears it; a simultaneous set wins.
- Simultaneous push and pop on the same FIFO: both take effect and the level is unchanged. On a full FIFO, a push is refused (ready low) even if a pop occurs that cycle.

## Timing
- TX latency: a push in cycle N into an empty FIFO with TX idle makes OUT_TX_SERIAL go low at the edge ending cycle N+2. OUT_TX_BUSY rises the same edge.
- Frame length in cycles: CLKS_PER_BIT × (1 + bits + parity + stops).
- RX: OUT_RX_VALID rises one cycle after the final stop-bit mid-sample. Synchronizer adds 2 cycles of sampling offset.
- OUT_TX_READY and OUT_RX_VALID are derived from registered levels and update the cycle after a push or pop.

## Configuration
- UART_FIFO_LOOPBACK_EN:
  - Defined: adds input IN_LOOPBACK (1 bit). When it is 1, the RX synchronizer input is taken from the internal TX serial, and OUT_TX_SERIAL is held at 1.
  - Undefined: the port is absent and RX always uses IN_RX_SERIAL.

## Structure
- Package uart_pkg holds:
  - parity encodings PARITY_NONE/ODD/EVEN;
  - TX and RX state enums;
  - CLKS_PER_BIT computation function.
- Sub-module uart_sync_fifo (width, depth parameters; first-word fall-through; level output). It is instantiated twice: TX at width NUM_OF_DATA_BITS_IN_PACK, RX at width +2 for the error tags.

## Test plan
- Push 0x55 with defaults, TX→RX cross-connect → RX word 0x55, tags 0, frame of 11 bits × 4 = 44 cycles, parity bit 0.
- Push 0x00,0x40,0x80,0xC0 back-to-back without popping → four RX words in order, no idle gap on the line, OUT_RX_LEVEL reaches 4.
- Inject a frame with its parity bit inverted, then one with the stop bit low → first word has PARITY_ERR=1, second has FRAME_ERR=1.
- Receive FIFO_DEPTH+1 frames with IN_RX_READY=0 → level equals FIFO_DEPTH, OUT_RX_OVERRUN=1, head word is the first frame. IN_OVERRUN_CLEAR then clears the flag.
- Glitch low for 1 cycle in IDLE → no push, FSM returns to IDLE.
- Assert IN_RESET_N=0 during TX data bit 3 → OUT_TX_SERIAL=1 at once, levels 0. After release, a new push of 0xA5 is received intact.
